rnbip_ctrl_fsm: RTL and testbench

//   Multi-cycle fetch/decode/sequence controller sitting directly upstream of the 8x8 register file.

---
 rtl/rnbip_ctrl_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_rnbip_ctrl_fsm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rnbip_ctrl_fsm.sv
// rnbip_ctrl_fsm
//   Fetch/decode/sequence controller for the 8x8 register file. It fetches
//   instruction bytes over a req/valid handshake, captures immediates into OR2,
//   and sequences the register-file controls and the ALU function code.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   imem_data   in   8  instruction byte at imem_addr
//   imem_valid  in   1  imem_data valid this cycle
//   imem_req    out  1  fetch request
//   imem_addr   out  8  program counter
//   or2         out  8  operand register 2 (immediate) to the register file
//   mux_sel     out  2  write source: 00=R0, 01=R[reg_sel], 10=OR2, 11=ALU
//   reg_sel     out  3  source register when mux_sel=01
//   seg         out  3  destination (write) / B-port (read) register
//   enab        out  2  00=clear all, 01=write, 11=read, 10=hold
//   alu_op      out  3  ALU function, meaningful from READ through WB
//   halted      out  1  set once HALT executes, cleared only by reset
//
// Every output is a flop. The next-state logic computes the values for the
// state being entered, so each output reflects the current state.
module rnbip_ctrl_fsm #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] imem_data,
  input  logic       imem_valid,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  output logic [7:0] or2,
  output logic [1:0] mux_sel,
  output logic [2:0] reg_sel,
  output logic [2:0] seg,
  output logic [1:0] enab,
  output logic [2:0] alu_op,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH2, S_EXEC,
    S_READ, S_ALU_WAIT, S_WB, S_HALT
  } state_t;

  localparam logic [1:0] EN_CLR  = 2'b00;
  localparam logic [1:0] EN_WR   = 2'b01;
  localparam logic [1:0] EN_HOLD = 2'b10;
  localparam logic [1:0] EN_RD   = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [6:0] ir_q, ir_d;        // {opcode, rd}; the reserved bit is not kept
  logic [7:0] or2_q, or2_d;
  logic [1:0] mux_sel_q, mux_sel_d;
  logic [2:0] reg_sel_q, reg_sel_d;
  logic [2:0] seg_q, seg_d;
  logic [1:0] enab_q, enab_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       req_q, req_d;
  logic       halted_q, halted_d;
  logic [2:0] wait_q, wait_d;

  logic [3:0] opc;
  logic [2:0] rd;
  logic       unused_rsvd;

  assign opc         = ir_q[6:3];
  assign rd          = ir_q[2:0];
  assign unused_rsvd = imem_data[3];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    or2_d     = or2_q;
    mux_sel_d = mux_sel_q;
    reg_sel_d = reg_sel_q;
    seg_d     = seg_q;
    alu_op_d  = alu_op_q;
    wait_d    = wait_q;
    enab_d    = EN_HOLD;
    req_d     = 1'b0;
    halted_d  = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = {imem_data[7:4], imem_data[2:0]};
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opc)
          4'h1, 4'h4: state_d = S_EXEC;
          4'h2, 4'h3: state_d = S_FETCH2;
          4'h7:       state_d = S_HALT;
          4'h0, 4'h5, 4'h6: state_d = S_FETCH;
          default: begin
            alu_op_d = opc[2:0];
            state_d  = S_READ;
          end
        endcase
      end
      S_FETCH2: begin
        if (imem_valid) begin
          pc_d = pc_q + 8'd1;
          if (opc == 4'h3) or2_d = imem_data;
          else             reg_sel_d = imem_data[2:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_FETCH;
      S_READ: begin
        // With a one-cycle ALU there is nothing to wait for.
        if (ALU_LAT > 1) begin
          wait_d  = 3'(ALU_LAT - 1);
          state_d = S_ALU_WAIT;
        end else begin
          state_d = S_WB;
        end
      end
      S_ALU_WAIT: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) state_d = S_WB;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Output values for the state being entered.
    req_d    = (state_d == S_FETCH) || (state_d == S_FETCH2);
    halted_d = (state_d == S_HALT);
    case (state_d)
      S_EXEC: begin
        seg_d = rd;
        case (opc)
          4'h2:    begin enab_d = EN_WR;  mux_sel_d = 2'b01; end
          4'h3:    begin enab_d = EN_WR;  mux_sel_d = 2'b10; end
          4'h4:    begin enab_d = EN_CLR; mux_sel_d = 2'b00; end
          default: begin enab_d = EN_WR;  mux_sel_d = 2'b00; end
        endcase
      end
      S_READ: begin
        enab_d = EN_RD;
        seg_d  = rd;
      end
      S_WB: begin
        enab_d    = EN_WR;
        mux_sel_d = 2'b11;
        seg_d     = 3'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 8'd0;
      ir_q      <= 7'd0;
      or2_q     <= 8'd0;
      mux_sel_q <= 2'b00;
      reg_sel_q <= 3'd0;
      seg_q     <= 3'd0;
      enab_q    <= EN_HOLD;
      alu_op_q  <= 3'd0;
      req_q     <= 1'b0;
      halted_q  <= 1'b0;
      wait_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      or2_q     <= or2_d;
      mux_sel_q <= mux_sel_d;
      reg_sel_q <= reg_sel_d;
      seg_q     <= seg_d;
      enab_q    <= enab_d;
      alu_op_q  <= alu_op_d;
      req_q     <= req_d;
      halted_q  <= halted_d;
      wait_q    <= wait_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign or2       = or2_q;
  assign mux_sel   = mux_sel_q;
  assign reg_sel   = reg_sel_q;
  assign seg       = seg_q;
  assign enab      = enab_q;
  assign alu_op    = alu_op_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_rnbip_ctrl_fsm.sv
// Bench for rnbip_ctrl_fsm with ALU_LAT=3. A table of instructions builds both
// program memory and a per-cycle expected trace (scoreboard queue); the trace
// is popped and compared on each falling edge. Hand-written sequences cover
// fetch stalls, reset during FETCH2, and HALT.
module tb_rnbip_ctrl_fsm;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] imem_data;
  logic       imem_valid;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] or2;
  logic [1:0] mux_sel;
  logic [2:0] reg_sel;
  logic [2:0] seg;
  logic [1:0] enab;
  logic [2:0] alu_op;
  logic       halted;

  logic [7:0] mem [256];

  assign imem_data  = mem[imem_addr];
  assign imem_valid = ~stall;

  always #5 clk = ~clk;

  rnbip_ctrl_fsm #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .imem_data(imem_data), .imem_valid(imem_valid),
    .imem_req(imem_req), .imem_addr(imem_addr), .or2(or2), .mux_sel(mux_sel),
    .reg_sel(reg_sel), .seg(seg), .enab(enab), .alu_op(alu_op), .halted(halted)
  );

  typedef struct {
    logic       req;
    logic [7:0] addr;
    logic [1:0] enab;
    logic [1:0] mux;
    logic [2:0] seg;
    logic [7:0] or2;
    logic [2:0] rsel;
    logic [2:0] alu;
    bit         cm, cs, ca;
  } rec_t;

  typedef enum {K_NOP, K_EXEC, K_TWO, K_ALU} kind_t;

  typedef struct {
    logic [7:0] b0, b1;
    kind_t      kind;
    logic [1:0] enab;
    logic [1:0] mux;
    logic [2:0] seg;
    logic [2:0] alu;
  } vec_t;

  rec_t       q[$];
  vec_t       tbl[12];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_or2;
  logic [2:0] m_rsel;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic req, input logic [7:0] addr, input logic [1:0] en,
                      input logic [1:0] mux, input logic [2:0] sg, input bit cm,
                      input bit cs, input logic [2:0] alu, input bit ca);
    rec_t r;
    r.req = req; r.addr = addr; r.enab = en; r.mux = mux; r.seg = sg;
    r.or2 = m_or2; r.rsel = m_rsel; r.alu = alu; r.cm = cm; r.cs = cs; r.ca = ca;
    q.push_back(r);
  endtask

  // Place one instruction at p in memory and append its expected cycles.
  task automatic gen(input vec_t v, inout logic [7:0] p);
    mem[p] = v.b0;
    push(1'b1, p, 2'b10, 2'b00, 3'd0, 0, 0, 3'd0, 0);          // FETCH
    p = p + 8'd1;
    push(1'b0, p, 2'b10, 2'b00, 3'd0, 0, 0, 3'd0, 0);          // DECODE
    case (v.kind)
      K_EXEC: push(1'b0, p, v.enab, v.mux, v.seg, v.enab == 2'b01, 1, 3'd0, 0);
      K_TWO: begin
        mem[p] = v.b1;
        push(1'b1, p, 2'b10, 2'b00, 3'd0, 0, 0, 3'd0, 0);      // FETCH2
        p = p + 8'd1;
        if (v.mux == 2'b10) m_or2 = v.b1;
        else                m_rsel = v.b1[2:0];
        push(1'b0, p, v.enab, v.mux, v.seg, 1, 1, 3'd0, 0);    // EXEC
      end
      K_ALU: begin
        push(1'b0, p, 2'b11, 2'b00, v.seg, 0, 1, v.alu, 1);    // READ
        for (int i = 0; i < LAT - 1; i++)
          push(1'b0, p, 2'b10, 2'b00, 3'd0, 0, 0, v.alu, 1);   // ALU_WAIT
        push(1'b0, p, 2'b01, 2'b11, 3'd0, 1, 1, v.alu, 1);     // WB
      end
      default: ;
    endcase
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    m_or2 = 8'd0;
    m_rsel = 3'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int   n;
    rec_t r;
    n = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      r = q.pop_front();
      chk($sformatf("c%0d.req", n), {7'd0, imem_req}, {7'd0, r.req});
      chk($sformatf("c%0d.addr", n), imem_addr, r.addr);
      chk($sformatf("c%0d.enab", n), {6'd0, enab}, {6'd0, r.enab});
      chk($sformatf("c%0d.or2", n), or2, r.or2);
      chk($sformatf("c%0d.reg_sel", n), {5'd0, reg_sel}, {5'd0, r.rsel});
      chk($sformatf("c%0d.halted", n), {7'd0, halted}, 8'd0);
      if (r.cm) chk($sformatf("c%0d.mux_sel", n), {6'd0, mux_sel}, {6'd0, r.mux});
      if (r.cs) chk($sformatf("c%0d.seg", n), {5'd0, seg}, {5'd0, r.seg});
      if (r.ca) chk($sformatf("c%0d.alu_op", n), {5'd0, alu_op}, {5'd0, r.alu});
      n++;
    end
  endtask

  initial begin
    logic [7:0] p;
    vec_t       nop;

    //        b0     b1     kind    enab   mux    seg   alu
    tbl[0]  = '{8'h35, 8'hA7, K_TWO,  2'b01, 2'b10, 3'd5, 3'd0};
    tbl[1]  = '{8'h93, 8'h00, K_ALU,  2'b11, 2'b00, 3'd3, 3'd1};
    tbl[2]  = '{8'h2A, 8'h06, K_TWO,  2'b01, 2'b01, 3'd2, 3'd0};
    tbl[3]  = '{8'h14, 8'h00, K_EXEC, 2'b01, 2'b00, 3'd4, 3'd0};
    tbl[4]  = '{8'h47, 8'h00, K_EXEC, 2'b00, 2'b00, 3'd7, 3'd0};
    tbl[5]  = '{8'h50, 8'h00, K_NOP,  2'b10, 2'b00, 3'd0, 3'd0};
    tbl[6]  = '{8'h61, 8'h00, K_NOP,  2'b10, 2'b00, 3'd0, 3'd0};
    tbl[7]  = '{8'hF1, 8'h00, K_ALU,  2'b11, 2'b00, 3'd1, 3'd7};
    tbl[8]  = '{8'h85, 8'h00, K_ALU,  2'b11, 2'b00, 3'd5, 3'd0};
    tbl[9]  = '{8'h3B, 8'h5C, K_TWO,  2'b01, 2'b10, 3'd3, 3'd0};
    tbl[10] = '{8'h0E, 8'h00, K_NOP,  2'b10, 2'b00, 3'd0, 3'd0};
    tbl[11] = '{8'h1F, 8'h00, K_EXEC, 2'b01, 2'b00, 3'd7, 3'd0};
    nop     = '{8'h00, 8'h00, K_NOP,  2'b10, 2'b00, 3'd0, 3'd0};

    // Reset values
    hold_reset();
    chk("rst.req", {7'd0, imem_req}, 8'd0);
    chk("rst.addr", imem_addr, 8'd0);
    chk("rst.or2", or2, 8'd0);
    chk("rst.mux_sel", {6'd0, mux_sel}, 8'd0);
    chk("rst.reg_sel", {5'd0, reg_sel}, 8'd0);
    chk("rst.seg", {5'd0, seg}, 8'd0);
    chk("rst.enab", {6'd0, enab}, 8'h02);
    chk("rst.alu_op", {5'd0, alu_op}, 8'd0);
    chk("rst.halted", {7'd0, halted}, 8'd0);

    // Table program followed by NOPs up to 0xFF and the wrap back to 0x00
    p = 8'd0;
    foreach (tbl[i]) gen(tbl[i], p);
    do gen(nop, p); while (p != 8'd0);
    push(1'b1, 8'h00, 2'b10, 2'b00, 3'd0, 0, 0, 3'd0, 0);
    rst_n = 1'b1;
    drain();

    // Fetch stall: valid low for three cycles
    hold_reset();
    mem[0] = 8'h14;
    stall = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.req", i), {7'd0, imem_req}, 8'd1);
      chk($sformatf("stall%0d.addr", i), imem_addr, 8'd0);
      chk($sformatf("stall%0d.enab", i), {6'd0, enab}, 8'h02);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("stall.dec_req", {7'd0, imem_req}, 8'd0);
    chk("stall.dec_addr", imem_addr, 8'd1);
    @(negedge clk);
    chk("stall.exec_enab", {6'd0, enab}, 8'h01);
    chk("stall.exec_seg", {5'd0, seg}, 8'd4);
    chk("stall.exec_addr", imem_addr, 8'd1);

    // Asynchronous reset during FETCH2 of MVI
    hold_reset();
    mem[0] = 8'h35;
    mem[1] = 8'hA7;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst.f2_req", {7'd0, imem_req}, 8'd1);
    chk("arst.f2_addr", imem_addr, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.enab", {6'd0, enab}, 8'h02);
    chk("arst.req", {7'd0, imem_req}, 8'd0);
    chk("arst.addr", imem_addr, 8'd0);
    chk("arst.or2", or2, 8'd0);
    @(negedge clk);
    chk("arst.hold_enab", {6'd0, enab}, 8'h02);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst.refetch_req", {7'd0, imem_req}, 8'd1);
    chk("arst.refetch_addr", imem_addr, 8'd0);
    repeat (3) @(negedge clk);
    chk("arst.exec_enab", {6'd0, enab}, 8'h01);
    chk("arst.exec_or2", or2, 8'hA7);
    chk("arst.exec_addr", imem_addr, 8'd2);

    // HALT followed by an available byte that must never be fetched
    hold_reset();
    mem[0] = 8'h70;
    mem[1] = 8'h12;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt.halted", {7'd0, halted}, 8'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("halt%0d.req", i), {7'd0, imem_req}, 8'd0);
      chk($sformatf("halt%0d.enab", i), {6'd0, enab}, 8'h02);
      chk($sformatf("halt%0d.addr", i), imem_addr, 8'd1);
      chk($sformatf("halt%0d.halted", i), {7'd0, halted}, 8'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
